// File: rtl/spi_burst_ctrl.sv
// spi_burst_ctrl: turns one register request (rw, addr, len) into a
// chip-select framed SPI burst driven over spi_master's start/new_data
// handshake. Sends a command byte {rw, addr}, then data bytes. Read bytes
// are streamed on rd_valid/rd_data, and done marks the end of the burst.
//
// Optional build macro: SPI_TIMEOUT_EN. It adds a per-byte watchdog
// (TIMEOUT cycles). The watchdog aborts the burst with err=1.
// Without the macro, WAIT waits forever and err is tied low.
module spi_burst_ctrl #(
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
`ifdef SPI_TIMEOUT_EN
  parameter int TIMEOUT  = 1023,
`endif
  parameter int LEN_W    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  input  logic             req_rw,
  input  logic [6:0]       req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic [7:0]       wr_data,
  output logic             busy,
  output logic             rd_valid,
  output logic [7:0]       rd_data,
  output logic             done,
  output logic             err,
  output logic             cs_n,
  output logic             spi_start,
  output logic [7:0]       spi_data_in,
  input  logic [7:0]       spi_data_out,
  input  logic             spi_busy,
  input  logic             spi_new_data
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_SEND, ST_WAIT, ST_HOLD, ST_FIN
  } state_t;

  localparam logic [7:0]   SETUP_LAST = 8'(CS_SETUP - 1);
  localparam logic [7:0]   HOLD_LAST  = 8'(CS_HOLD - 1);
  localparam logic [LEN_W:0] IDX_ONE  = (LEN_W+1)'(1);

  state_t         state_reg;
  logic           rw_reg;
  logic [6:0]     addr_reg;
  logic [7:0]     wdata_reg;
  // Index of the final byte of the burst (command byte is index 0)
  logic [LEN_W:0] last_idx_reg;
  logic [LEN_W:0] idx_reg;
  // Shared by the cs setup and cs hold phases
  logic [7:0]     cnt_reg;

`ifdef SPI_TIMEOUT_EN
  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  logic [TO_W-1:0] to_cnt_reg;
  logic            err_reg;
  assign err = err_reg;
`else
  assign err = 1'b0;
`endif

  // Burst sequencer. All outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      rw_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      last_idx_reg <= '0;
      idx_reg      <= '0;
      cnt_reg      <= '0;
      busy         <= 1'b0;
      rd_valid     <= 1'b0;
      rd_data      <= '0;
      done         <= 1'b0;
      cs_n         <= 1'b1;
      spi_start    <= 1'b0;
      spi_data_in  <= '0;
`ifdef SPI_TIMEOUT_EN
      to_cnt_reg   <= '0;
      err_reg      <= 1'b0;
`endif
    end else begin
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      spi_start <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          // Hold off while spi_master is still busy from earlier traffic
          if (req && !spi_busy) begin
            rw_reg       <= req_rw;
            addr_reg     <= req_addr;
            wdata_reg    <= wr_data;
            // Read: command + req_len bytes. Write: command + one data byte.
            last_idx_reg <= req_rw ? {1'b0, req_len} : IDX_ONE;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            busy         <= 1'b1;
            cs_n         <= 1'b0;
            state_reg    <= ST_SETUP;
`ifdef SPI_TIMEOUT_EN
            err_reg      <= 1'b0;
`endif
          end
        end
        ST_SETUP: begin
          if (cnt_reg == SETUP_LAST) begin
            state_reg <= ST_SEND;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ST_SEND: begin
          spi_start <= 1'b1;
          if (idx_reg == '0) begin
            spi_data_in <= {rw_reg, addr_reg};
          end else if (rw_reg) begin
            spi_data_in <= 8'h00;
          end else begin
            spi_data_in <= wdata_reg;
          end
`ifdef SPI_TIMEOUT_EN
          to_cnt_reg <= '0;
`endif
          state_reg <= ST_WAIT;
        end
        ST_WAIT: begin
          if (spi_new_data) begin
            // The byte clocked in during the command byte is never reported
            if (rw_reg && (idx_reg != '0)) begin
              rd_data  <= spi_data_out;
              rd_valid <= 1'b1;
            end
            idx_reg <= idx_reg + IDX_ONE;
            if (idx_reg == last_idx_reg) begin
              cnt_reg   <= '0;
              state_reg <= ST_HOLD;
            end else begin
              state_reg <= ST_SEND;
            end
          end
`ifdef SPI_TIMEOUT_EN
          else if (to_cnt_reg == TO_LAST) begin
            // Abort: release the slave right away and flag the error
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            err_reg   <= 1'b1;
            state_reg <= ST_FIN;
          end else begin
            to_cnt_reg <= to_cnt_reg + TO_W'(1);
          end
`endif
        end
        ST_HOLD: begin
          if (cnt_reg == HOLD_LAST) begin
            cs_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= ST_FIN;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
        ST_FIN: begin
          // One idle-side cycle with cs_n high before the next request is seen
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_burst_ctrl.sv
// Testbench for spi_burst_ctrl. A behavioural spi_master responder sits
// on the SPI side. Expected bursts come from the transaction rules:
// byte list, read data and frame timing.
module tb_spi_burst_ctrl;
  localparam int CS_SETUP = 3;
  localparam int CS_HOLD  = 5;
  localparam int LEN_W    = 4;
`ifdef SPI_TIMEOUT_EN
  localparam int TO_LIM   = 20;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             req;
  logic             req_rw;
  logic [6:0]       req_addr;
  logic [LEN_W-1:0] req_len;
  logic [7:0]       wr_data;
  logic             busy, rd_valid, done, err, cs_n, spi_start;
  logic [7:0]       rd_data, spi_data_in, spi_data_out;
  logic             spi_busy, spi_new_data;
  logic             model_busy, force_busy;

  assign spi_busy = model_busy | force_busy;

  always #5 clk = ~clk;

  spi_burst_ctrl #(
    .CS_SETUP(CS_SETUP),
    .CS_HOLD (CS_HOLD),
`ifdef SPI_TIMEOUT_EN
    .TIMEOUT (TO_LIM),
`endif
    .LEN_W   (LEN_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_len(req_len), .wr_data(wr_data), .busy(busy), .rd_valid(rd_valid),
    .rd_data(rd_data), .done(done), .err(err), .cs_n(cs_n), .spi_start(spi_start),
    .spi_data_in(spi_data_in), .spi_data_out(spi_data_out), .spi_busy(spi_busy),
    .spi_new_data(spi_new_data)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- spi_master responder ----------------
  logic [7:0] resp_q[$];
  logic [7:0] sent_q[$];
  int         start_cyc_q[$];
  int         last_nd_cyc = 0;
  bit         spi_mute = 1'b0;
  bit         spi_idle = 1'b1;

  initial begin
    model_busy = 1'b0;
    spi_new_data = 1'b0;
    spi_data_out = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (spi_start) begin
        sent_q.push_back(spi_data_in);
        start_cyc_q.push_back(cyc);
        if (!spi_mute) begin
          spi_idle = 1'b0;
          model_busy = 1'b1;
          repeat ($urandom_range(5, 1)) @(posedge clk);
          #1;
          if (resp_q.size() != 0) spi_data_out = resp_q.pop_front();
          else spi_data_out = 8'hEE;
          spi_new_data = 1'b1;
          last_nd_cyc = cyc;
          @(posedge clk); #1;
          spi_new_data = 1'b0;
          model_busy = 1'b0;
          spi_idle = 1'b1;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [7:0] rd_q[$];
  int done_cnt = 0;
  int fall_cnt = 0;
  int rise_cyc = 0;
  int gap = 0;
  int bad_start = 0;
  bit prev_cs = 1'b1;

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rd_valid) rd_q.push_back(rd_data);
      if (done) done_cnt++;
      if (!cs_n && prev_cs) begin
        fall_cnt++;
        gap = cyc - rise_cyc;
      end
      if (cs_n && !prev_cs) rise_cyc = cyc;
      if (spi_start && cs_n) bad_start++;
      prev_cs = cs_n;
    end
  end

  // ---------------- reference model and transaction helpers ----------------
  logic [7:0] exp_tx[$];
  logic [7:0] exp_rd[$];

  task automatic wait_spi_idle();
    bit ok = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (spi_idle && !spi_new_data) begin
        ok = 1'b1;
        break;
      end
    end
    check("spi_idle_wait", int'(ok), 1);
  endtask

  // Build expectations from the burst rules, load responses and raise req
  task automatic prepare(input bit rw, input logic [6:0] addr, input logic [LEN_W-1:0] len,
                         input logic [7:0] wd, input bit fixed_resp);
    int nb;
    logic [7:0] r;
    wait_spi_idle();
    sent_q.delete(); start_cyc_q.delete(); rd_q.delete(); resp_q.delete();
    exp_tx.delete(); exp_rd.delete();
    done_cnt = 0;
    fall_cnt = 0;
    nb = rw ? int'(len) + 1 : 2;
    exp_tx.push_back({rw, addr});
    for (int i = 1; i < nb; i++) exp_tx.push_back(rw ? 8'h00 : wd);
    for (int i = 0; i < nb; i++) begin
      r = fixed_resp ? 8'(8'hA0 + i) : 8'($urandom);
      resp_q.push_back(r);
      if (rw && i > 0) exp_rd.push_back(r);
    end
    req_rw = rw; req_addr = addr; req_len = len; wr_data = wd;
    req = 1'b1;
  endtask

  task automatic wait_accept(output bit seen, output int acc_cyc);
    seen = 1'b0;
    acc_cyc = 0;
    for (int k = 0; k < 100; k++) begin
      @(posedge clk); #1;
      if (!cs_n) begin
        seen = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic wait_done(input int limit, output bit seen, output int d_cyc);
    seen = 1'b0;
    d_cyc = 0;
    for (int k = 0; k < limit; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        d_cyc = cyc;
        break;
      end
    end
  endtask

  // Run the prepared request to completion and compare it against the model
  task automatic complete(input string tag);
    bit seen;
    int acc_cyc, d_cyc, n;
    wait_accept(seen, acc_cyc);
    check({tag, ".accept"}, int'(seen), 1);
    if (!seen) begin
      req = 1'b0;
      return;
    end
    check({tag, ".busy_on"}, int'(busy), 1);
    check({tag, ".err_clr"}, int'(err), 0);
    // Scramble request inputs while busy; they must have no effect
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      req_rw = 1'($urandom); req_addr = 7'($urandom);
      req_len = LEN_W'($urandom); wr_data = 8'($urandom);
    end
    req = 1'b0;
    wait_done(4000, seen, d_cyc);
    check({tag, ".done_seen"}, int'(seen), 1);
    check({tag, ".cs_n_at_done"}, int'(cs_n), 1);
    check({tag, ".busy_at_done"}, int'(busy), 0);
    check({tag, ".err_at_done"}, int'(err), 0);
    repeat (4) @(posedge clk);
    #1;
    check({tag, ".done_cnt"}, done_cnt, 1);
    check({tag, ".tx_cnt"}, sent_q.size(), exp_tx.size());
    n = (sent_q.size() < exp_tx.size()) ? sent_q.size() : exp_tx.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.tx%0d", tag, i), int'(sent_q[i]), int'(exp_tx[i]));
    check({tag, ".rd_cnt"}, rd_q.size(), exp_rd.size());
    n = (rd_q.size() < exp_rd.size()) ? rd_q.size() : exp_rd.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s.rd%0d", tag, i), int'(rd_q[i]), int'(exp_rd[i]));
    check({tag, ".setup_lat"}, (start_cyc_q.size() > 0) ? start_cyc_q[0] - acc_cyc : -1,
          CS_SETUP + 1);
    check({tag, ".hold_lat"}, d_cyc - (last_nd_cyc + 1), CS_HOLD);
    check({tag, ".start_in_cs_high"}, bad_start, 0);
    $display("txn %s rw=%0d addr=0x%02h bytes=%0d rd=%0d done@%0d", tag, exp_tx[0][7],
             exp_tx[0][6:0], sent_q.size(), rd_q.size(), d_cyc);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit               rw;
    logic [6:0]       addr;
    logic [LEN_W-1:0] len;
    logic [7:0]       wd;
    logic [7:0]       exp_first;
    int               exp_nbytes;
    int               exp_nrd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit seen;
    int acc_cyc, d_cyc, cnt;
    logic [7:0] b0, b1;

    vecs[0] = '{1'b1, 7'h3B, 4'd6,  8'h00, 8'hBB, 7,  6};
    vecs[1] = '{1'b0, 7'h6B, 4'd9,  8'h80, 8'h6B, 2,  0};
    vecs[2] = '{1'b1, 7'h75, 4'd0,  8'h00, 8'hF5, 1,  0};
    vecs[3] = '{1'b1, 7'h7F, 4'd15, 8'h00, 8'hFF, 16, 15};
    vecs[4] = '{1'b0, 7'h00, 4'd0,  8'hFF, 8'h00, 2,  0};
    vecs[5] = '{1'b1, 7'h01, 4'd1,  8'h00, 8'h81, 2,  1};

    rst_n = 1'b0; req = 1'b0; req_rw = 1'b0; req_addr = '0; req_len = '0;
    wr_data = '0; force_busy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.busy", int'(busy), 0);
    check("reset.cs_n", int'(cs_n), 1);
    check("reset.done", int'(done), 0);
    check("reset.err", int'(err), 0);
    check("reset.rd_valid", int'(rd_valid), 0);
    check("reset.rd_data", int'(rd_data), 0);
    check("reset.spi_start", int'(spi_start), 0);
    check("reset.spi_data_in", int'(spi_data_in), 0);
    rst_n = 1'b1;

    // Table-driven directed transactions
    for (int i = 0; i < 6; i++) begin
      prepare(vecs[i].rw, vecs[i].addr, vecs[i].len, vecs[i].wd, 1'b1);
      complete($sformatf("vec%0d", i));
      check($sformatf("vec%0d.nbytes", i), sent_q.size(), vecs[i].exp_nbytes);
      check($sformatf("vec%0d.first", i), (sent_q.size() > 0) ? int'(sent_q[0]) : -1,
            int'(vecs[i].exp_first));
      check($sformatf("vec%0d.nrd", i), rd_q.size(), vecs[i].exp_nrd);
    end

    // Request held off while spi_master reports busy
    force_busy = 1'b1;
    prepare(1'b0, 7'h12, 4'd0, 8'h34, 1'b0);
    cnt = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!cs_n || busy) cnt++;
    end
    check("holdoff.no_accept", cnt, 0);
    force_busy = 1'b0;
    complete("holdoff");

    // Reset during the third byte of a 6-byte read
    prepare(1'b1, 7'h3B, 4'd6, 8'h00, 1'b1);
    wait_accept(seen, acc_cyc);
    check("rst_mid.accept", int'(seen), 1);
    req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(posedge clk); #1;
      if (sent_q.size() >= 3) begin
        seen = 1'b1;
        break;
      end
    end
    check("rst_mid.third_byte", int'(seen), 1);
    check("rst_mid.cs_low_before", int'(cs_n), 0);
    done_cnt = 0;
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid.cs_n", int'(cs_n), 1);
    check("rst_mid.busy", int'(busy), 0);
    check("rst_mid.spi_start", int'(spi_start), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wait_spi_idle();
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid.no_done", done_cnt, 0);
    prepare(1'b1, 7'h3B, 4'd6, 8'h00, 1'b1);
    complete("after_rst");

    // Back-to-back writes with req held high throughout
    prepare(1'b0, 7'h22, 4'd3, 8'h5A, 1'b0);
    b0 = exp_tx[0];
    b1 = exp_tx[1];
    exp_tx.push_back(b0);
    exp_tx.push_back(b1);
    cnt = 0;
    for (int k = 0; k < 800; k++) begin
      @(posedge clk); #1;
      if (done) cnt++;
      if (cnt == 2) break;
    end
    req = 1'b0;
    check("b2b.done_seen", cnt, 2);
    repeat (6) @(posedge clk);
    #1;
    check("b2b.done_cnt", done_cnt, 2);
    check("b2b.frames", fall_cnt, 2);
    check("b2b.gap_ge1", int'(gap >= 1), 1);
    check("b2b.tx_cnt", sent_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("b2b.tx%0d", i), (sent_q.size() > i) ? int'(sent_q[i]) : -1,
            int'(exp_tx[i]));
    check("b2b.rd_cnt", rd_q.size(), 0);
    $display("txn b2b frames=%0d bytes=%0d gap=%0d", fall_cnt, sent_q.size(), gap);

`ifdef SPI_TIMEOUT_EN
    // Slave never answers: watchdog must abort the burst
    spi_mute = 1'b1;
    prepare(1'b1, 7'h10, 4'd2, 8'h00, 1'b1);
    wait_accept(seen, acc_cyc);
    check("tout.accept", int'(seen), 1);
    req = 1'b0;
    wait_done(300, seen, d_cyc);
    check("tout.done_seen", int'(seen), 1);
    check("tout.latency", (start_cyc_q.size() > 0) ? d_cyc - start_cyc_q[0] : -1, TO_LIM);
    check("tout.err", int'(err), 1);
    check("tout.cs_n", int'(cs_n), 1);
    check("tout.busy", int'(busy), 0);
    check("tout.tx_cnt", sent_q.size(), 1);
    repeat (5) @(posedge clk);
    #1;
    check("tout.err_held", int'(err), 1);
    check("tout.done_cnt", done_cnt, 1);
    $display("txn timeout done@%0d err=%0d", d_cyc, err);
    spi_mute = 1'b0;
    prepare(1'b0, 7'h11, 4'd0, 8'h22, 1'b0);
    complete("after_tout");
`endif

    // Randomized transactions against the model
    for (int t = 0; t < 20; t++) begin
      prepare(1'($urandom), 7'($urandom), LEN_W'($urandom), 8'($urandom), 1'b0);
      complete($sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
